alu_mw_seq: RTL and testbench

Multi-word operation sequencer that drives the single-word `alu` as its initiator. It accepts a command (opcode, word count, initial carry), then streams operand word pairs least-significant first and feeds them through the ALU. It chains carry/borrow between words, accumulates flags across the whole operand, and streams result words out. It sits between the datapath's operand buffers and the combinational ALU, giving arbitrary-precision ADC/SBB and logic operations.

---
 rtl/alu_mw_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_mw_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mw_seq.sv
// alu_mw_seq: multi-word operation sequencer wrapped around the single-word ALU.
// Takes a command (opcode, word count, carry in), streams operand word pairs
// least-significant first through the ALU, chains carry/borrow between words,
// accumulates the zero flag across the whole operand, and streams result
// words out through a single-entry output register.

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module alu_mw_seq #(
    parameter int width       = `WORD_WIDTH,
    parameter int flags_width = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    // command channel
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_opcode,
    input  logic [7:0]             cmd_words,
    input  logic                   cmd_carry,
    // operand stream
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [width-1:0]       op_a,
    input  logic [width-1:0]       op_b,
    // result stream
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [width-1:0]       res_data,
    output logic                   res_last,
    // ALU side
    output logic                   alu_oe,
    output logic [3:0]             alu_opcode,
    output logic [width-1:0]       alu_in1,
    output logic [width-1:0]       alu_in2,
    output logic                   alu_carry,
    input  logic [width-1:0]       alu_out,
    input  logic [flags_width-1:0] alu_flags,
    // status
    output logic                   busy,
    output logic                   done,
    output logic [flags_width-1:0] flags
);

    // flag vector bit positions: {P, S, Z, O, C}
    localparam int FC = 0;
    localparam int FO = 1;
    localparam int FZ = 2;
    localparam int FS = 3;
    localparam int FP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [3:0]             opcode_r;
    logic                   carry_r;
    logic [7:0]             remaining_r;
    logic                   z_acc_r;
    logic                   p_r;
    logic                   s_r;
    logic                   o_r;
    logic [width-1:0]       res_data_r;
    logic                   res_valid_r;
    logic                   res_last_r;
    logic [flags_width-1:0] flags_r;

    logic                   run_s;
    logic                   op_ready_s;
    logic                   op_hs_s;
    logic                   res_hs_s;

    // Handshake decode; the output register is one entry deep, so a new
    // operand is taken only when that entry is empty or leaving this cycle.
    always_comb begin
        run_s      = (state_r == RUN);
        op_ready_s = 1'b0;
        if (run_s) begin
            op_ready_s = !res_valid_r || res_ready;
        end else begin
            op_ready_s = 1'b0;
        end
        op_hs_s  = op_ready_s && op_valid;
        res_hs_s = res_valid_r && res_ready;
    end

    // Output drive; ALU operands pass straight through only while running so
    // the ALU sees quiet zero inputs in every other state.
    always_comb begin
        cmd_ready  = (state_r == IDLE);
        busy       = (state_r != IDLE);
        done       = (state_r == DONE);
        op_ready   = op_ready_s;
        res_valid  = res_valid_r;
        res_data   = res_data_r;
        res_last   = res_last_r;
        flags      = flags_r;
        alu_opcode = opcode_r;
        alu_oe     = run_s;
        if (run_s) begin
            alu_in1   = op_a;
            alu_in2   = op_b;
            alu_carry = carry_r;
        end else begin
            alu_in1   = {width{1'b0}};
            alu_in2   = {width{1'b0}};
            alu_carry = 1'b0;
        end
    end

    // Sequencer FSM with carry chaining, flag accumulation and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            opcode_r    <= 4'd0;
            carry_r     <= 1'b0;
            remaining_r <= 8'd0;
            z_acc_r     <= 1'b0;
            p_r         <= 1'b0;
            s_r         <= 1'b0;
            o_r         <= 1'b0;
            res_data_r  <= {width{1'b0}};
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            flags_r     <= {flags_width{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        opcode_r    <= cmd_opcode;
                        carry_r     <= cmd_carry;
                        remaining_r <= cmd_words;
                        z_acc_r     <= 1'b1;
                        res_last_r  <= 1'b0;
                        if (cmd_words != 8'd0) begin
                            flags_r <= {flags_width{1'b0}};
                            state_r <= RUN;
                        end else begin
                            // an empty operand reads as zero with even parity
                            flags_r <= 5'b10100;
                            state_r <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (op_hs_s) begin
                        res_data_r  <= alu_out;
                        res_valid_r <= 1'b1;
                        carry_r     <= alu_flags[FC];
                        z_acc_r     <= z_acc_r & alu_flags[FZ];
                        p_r         <= alu_flags[FP];
                        s_r         <= alu_flags[FS];
                        o_r         <= alu_flags[FO];
                        remaining_r <= remaining_r - 8'd1;
                        if (remaining_r == 8'd1) begin
                            res_last_r <= 1'b1;
                            state_r    <= DRAIN;
                        end else begin
                            res_last_r <= 1'b0;
                            state_r    <= RUN;
                        end
                    end else if (res_hs_s) begin
                        res_valid_r <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (res_hs_s) begin
                        res_valid_r <= 1'b0;
                        res_last_r  <= 1'b0;
                        flags_r     <= {p_r, s_r, z_acc_r, o_r, carry_r};
                        state_r     <= DONE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mw_seq.sv
// tb_alu_mw_seq: randomized self-checking bench for alu_mw_seq. The bench
// plays the single-word ALU, computes expected multi-word results and final
// flags from the ALU rules, and checks the result stream and flags every cycle.

module tb_alu_mw_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [7:0]   cmd_words;
    logic         cmd_carry;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_last;
    logic         alu_oe;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic         alu_carry;
    logic [W-1:0] alu_out;
    logic [4:0]   alu_flags;
    logic         busy;
    logic         done;
    logic [4:0]   flags;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rr_mode  = 0;   // 0: res_ready always 1, 1: random, 2: driven by a script

    logic [W-1:0] va [0:255];
    logic [W-1:0] vb [0:255];
    logic [W-1:0] exp_data_q [$];
    logic         exp_last_q [$];
    logic [4:0]   exp_flags_q [$];
    logic [W-1:0] got_q [$];
    logic [4:0]   last_flags;

    alu_mw_seq #(.width(W), .flags_width(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_words(cmd_words), .cmd_carry(cmd_carry),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .alu_oe(alu_oe), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_carry(alu_carry), .alu_out(alu_out), .alu_flags(alu_flags),
        .busy(busy), .done(done), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Single-word ALU: returns {P, S, Z, O, C, result}.
    function automatic logic [W+4:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        t = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; r = t[W-1:0]; c = t[W];
                        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin}; r = t[W-1:0]; c = t[W];
                        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: begin t = {1'b0, b} - {1'b0, a} - {{W{1'b0}}, cin}; r = t[W-1:0]; c = t[W];
                        o = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]); end
            4'd3: r = ~a;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: begin r = {a[W-2:0], 1'b0};     c = a[W-1]; end
            4'd8: begin r = {1'b0, a[W-1:1]};     c = a[0];   end
            4'd9: begin r = {a[W-1], a[W-1:1]};   c = a[0];   end
            default: r = '0;
        endcase
        return {~^r, r[W-1], (r == '0), o, c, r};
    endfunction

    // bench-side ALU
    logic [W+4:0] alu_res_s;
    always_comb begin
        alu_res_s = alu_fn(alu_opcode, alu_in1, alu_in2, alu_carry);
        alu_out   = alu_oe ? alu_res_s[W-1:0] : '0;
        alu_flags = alu_oe ? alu_res_s[W+4:W] : 5'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // res_ready driver
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) res_ready = 1'b1;
            else if (rr_mode == 1) res_ready = 1'($urandom_range(0, 1));
        end
    end

    // compare process: result stream, stall stability, flags at done, idle gating
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", res_valid, 32'd1);
                    chk("stall_data", res_data, prev_data);
                    chk("stall_last", res_last, prev_last);
                end
                if (res_valid && res_ready) begin
                    chk("res_expected", exp_data_q.size() > 0, 32'd1);
                    if (exp_data_q.size() > 0) begin
                        chk("res_data", res_data, exp_data_q.pop_front());
                        chk("res_last", res_last, exp_last_q.pop_front());
                        got_q.push_back(res_data);
                    end
                end
                if (done) begin
                    chk("done_expected", exp_flags_q.size() > 0, 32'd1);
                    if (exp_flags_q.size() > 0) chk("flags", flags, exp_flags_q.pop_front());
                    last_flags = flags;
                end
                if (cmd_ready) chk("op_ready_idle", op_ready, 32'd0);
                if (alu_oe) chk("alu_in1_pass", alu_in1, op_a);
                prev_stall = res_valid && !res_ready;
                prev_data  = res_data;
                prev_last  = res_last;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 32'd1);
        chk({tag, "_op_ready"}, op_ready, 32'd0);
        chk({tag, "_res_valid"}, res_valid, 32'd0);
        chk({tag, "_res_last"}, res_last, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk({tag, "_alu_oe"}, alu_oe, 32'd0);
        chk({tag, "_alu_opcode"}, alu_opcode, 32'd0);
        chk({tag, "_alu_carry"}, alu_carry, 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_in2"}, alu_in2, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_done"}, done, 32'd0);
        chk({tag, "_flags"}, flags, 32'd0);
    endtask

    task automatic send_cmd(input logic [3:0] op, input int n, input logic cin,
                            input int mode, output int k);
        bit hs;
        int g;
        hs = 1'b0; g = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_words = n[7:0]; cmd_carry = cin;
        while (!hs && g < 100) begin
            @(negedge clk);
            hs = cmd_ready;
            g++;
            @(posedge clk);
            #1;
        end
        k = cyc;
        chk("cmd_accept", hs, 32'd1);
        // in random mode keep offering a bogus command; it must be ignored while busy
        cmd_valid = (mode == 1);
        cmd_opcode = 4'd6; cmd_words = 8'd0; cmd_carry = 1'b1;
    endtask

    task automatic feed(input int n, input int mode);
        bit hs;
        int g;
        for (int i = 0; i < n; i++) begin
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                op_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            hs = 1'b0; g = 0;
            op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
            while (!hs && g < 200) begin
                @(negedge clk);
                hs = op_ready;
                g++;
                @(posedge clk);
                #1;
            end
            chk("op_handshake", hs, 32'd1);
            if (!hs) break;
        end
        op_valid = 1'b0;
    endtask

    // hold res_ready low for three cycles mid-stream, then go random
    task automatic bp_script();
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_op_ready", op_ready, 32'd0);
            chk("bp_res_valid", res_valid, 32'd1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        rr_mode = 1;
    endtask

    task automatic run_cmd(input logic [3:0] op, input int n, input logic cin, input int mode);
        logic [W+4:0] x;
        logic         c;
        logic         z;
        logic [4:0]   lf;
        int           k;
        int           cnt;
        bit           seen;
        // expected word stream and final flags
        c = cin; z = 1'b1; lf = 5'b10100;
        for (int i = 0; i < n; i++) begin
            x = alu_fn(op, va[i], vb[i], c);
            exp_data_q.push_back(x[W-1:0]);
            exp_last_q.push_back(i == n - 1);
            c  = x[W];
            z  = z & x[W+2];
            lf = {x[W+4], x[W+3], z, x[W+1], c};
        end
        exp_flags_q.push_back(lf);
        got_q.delete();
        rr_mode = (mode == 2) ? 2 : mode;
        if (mode == 2) res_ready = 1'b1;
        send_cmd(op, n, cin, mode, k);
        fork
            feed(n, mode);
            begin
                if (mode == 2) bp_script();
            end
        join
        cmd_valid = 1'b0;
        cnt = 0; seen = 1'b0;
        while (cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (cmd_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idle_reached", seen, 32'd1);
        // with no stalls: N word cycles, one drain, one done cycle
        if (mode == 0) chk("latency", cyc - k, (n == 0) ? 32'd1 : 32'(n + 2));
        chk("no_lost_words", exp_data_q.size(), 32'd0);
        chk("flags_consumed", exp_flags_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_words = 8'd0; cmd_carry = 1'b0;
        op_valid = 1'b0; op_a = '0; op_b = '0; rr_mode = 0; last_flags = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADC two words: 0x0001FFFF + 0x00000001
        va[0] = 16'hFFFF; va[1] = 16'h0001; vb[0] = 16'h0001; vb[1] = 16'h0000;
        run_cmd(4'd0, 2, 1'b0, 0);
        chk("adc_w0", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 32'h0000);
        chk("adc_w1", got_q.size() > 1 ? got_q[1] : 16'hDEAD, 32'h0002);
        chk("adc_flags", last_flags, 32'h00);

        // SBB1 two words: 0 - 1 borrows through both words
        va[0] = 16'h0000; va[1] = 16'h0000; vb[0] = 16'h0001; vb[1] = 16'h0000;
        run_cmd(4'd1, 2, 1'b0, 0);
        chk("sbb_w0", got_q.size() > 0 ? got_q[0] : 16'h0, 32'hFFFF);
        chk("sbb_w1", got_q.size() > 1 ? got_q[1] : 16'h0, 32'hFFFF);
        chk("sbb_flags", last_flags, 32'h19);

        // XOR identical, then middle word differing
        for (int i = 0; i < 3; i++) begin va[i] = W'($urandom); vb[i] = va[i]; end
        run_cmd(4'd6, 3, 1'b0, 0);
        chk("xor_eq_flags", last_flags, 32'h14);
        vb[1] = va[1] ^ 16'h0100;
        run_cmd(4'd6, 3, 1'b0, 0);
        chk("xor_ne_z", last_flags[2], 32'd0);

        // zero-length command with carry in set
        run_cmd(4'd0, 0, 1'b1, 0);
        chk("zero_len_flags", last_flags, 32'h14);

        // backpressure mid-stream
        for (int i = 0; i < 8; i++) begin va[i] = W'($urandom); vb[i] = W'($urandom); end
        run_cmd(4'd0, 8, 1'b1, 2);

        // random commands
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin va[i] = W'($urandom); vb[i] = W'($urandom); end
            run_cmd(4'($urandom_range(0, 15)), n, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1));
        end

        // reset after one of four words
        rr_mode = 0;
        for (int i = 0; i < 4; i++) begin va[i] = W'($urandom); vb[i] = W'($urandom); end
        send_cmd(4'd0, 4, 1'b0, 0, k);
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = va[0]; op_b = vb[0];
        @(negedge clk);
        chk("rst_op_ready", op_ready, 32'd1);
        @(posedge clk);
        #1;
        op_a = 16'hA5A5; op_b = 16'h5A5A;
        rst = 1'b1;
        exp_data_q.delete(); exp_last_q.delete(); exp_flags_q.delete();
        @(negedge clk);
        check_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        va[0] = 16'h0001; vb[0] = 16'h0001;
        run_cmd(4'd0, 1, 1'b0, 0);
        chk("after_rst_w0", got_q.size() > 0 ? got_q[0] : 16'h0, 32'h0002);
        chk("after_rst_flags", last_flags, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
